popcount_pattern_gen: RTL and testbench

//   Inverse of the bit counter. Given a target ones-count K, the block

---
 rtl/popcount_pattern_gen.sv | 136 +++++++++++++
 tb/tb_popcount_pattern_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly K ones, in ascending order, over a
// valid/ready stream. Successor words are produced by Gosper's hack with no divider.
module popcount_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KW-1:0]    k,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_last,
    output logic [WIDTH-1:0] out_index,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] index_q, index_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   ones_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH:0]   w_ext_s, c_s, r_s, x_s, next_s;
    logic             k_bad_s;

    // Position of the single set bit in a one-hot (or zero) vector.
    function automatic logic [KW-1:0] tz_f(input logic [WIDTH:0] v);
        logic [KW-1:0] pos;
        pos = '0;
        for (int i = WIDTH; i >= 0; i--) begin
            if (v[i]) begin
                pos = KW'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // First and final pattern of the sweep for the requested k.
    assign ones_s  = ({{WIDTH{1'b0}}, 1'b1} << k) - {{WIDTH{1'b0}}, 1'b1};
    assign top_s   = ones_s[WIDTH-1:0] << (KW'(WIDTH) - k);
    assign k_bad_s = ({1'b0, k} > (KW + 1)'(WIDTH));

    // Successor is evaluated one bit wider so the carry out of r is not lost.
    assign w_ext_s = {1'b0, word_q};
    assign c_s     = w_ext_s & (~w_ext_s + {{WIDTH{1'b0}}, 1'b1});
    assign r_s     = w_ext_s + c_s;
    assign x_s     = (r_s ^ w_ext_s) >> 2;
    assign next_s  = r_s | (x_s >> tz_f(c_s));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        index_d = index_q;
        top_d   = top_q;
        last_d  = last_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && k_bad_s) begin
                    err_d = 1'b1;
                end else if (start) begin
                    state_d = EMIT;
                    word_d  = ones_s[WIDTH-1:0];
                    index_d = '0;
                    top_d   = top_s;
                    last_d  = (ones_s[WIDTH-1:0] == top_s);
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (out_ready && last_q) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (out_ready) begin
                    word_d  = next_s[WIDTH-1:0];
                    index_d = index_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    last_d  = (next_s[WIDTH-1:0] == top_q);
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            index_q <= '0;
            top_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            index_q <= index_d;
            top_q   <= top_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == EMIT);
    assign out_valid = (state_q == EMIT);
    assign out_word  = word_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Scoreboard bench for popcount_pattern_gen: expected sweeps come from a brute-force
// enumeration of all 8-bit words, compared as the DUT streams them out.
module tb_popcount_pattern_gen;

    localparam int WIDTH = 8;
    localparam int KW    = 4;

    typedef struct {
        logic [7:0] word;
        logic [7:0] idx;
        logic       last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [KW-1:0]    k;
    logic             busy, err, out_valid, out_ready, out_last, done;
    logic [WIDTH-1:0] out_word, out_index;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_k = 0;
    int   binom[9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};

    popcount_pattern_gen #(.WIDTH(WIDTH), .KW(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k(k), .busy(busy), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .out_index(out_index), .done(done)
    );

    always #5 clk = ~clk;

    task automatic push_expected(input int kk);
        exp_t       e;
        int         idx;
        logic [7:0] wv;
        idx = 0;
        for (int w = 0; w < 256; w++) begin
            wv = w[7:0];
            if ($countones(wv) == kk) begin
                e.word = wv;
                e.idx  = idx[7:0];
                e.last = 1'b0;
                sb.push_back(e);
                idx++;
            end
        end
        sb[sb.size() - 1].last = 1'b1;
    endtask

    // Called at a negedge; leaves the bench at the negedge after start was sampled.
    task automatic start_sweep(input int kk);
        cur_k = kk;
        push_expected(kk);
        start = 1'b1;
        k     = kk[KW-1:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int ready_pct, input int inject_at, input int stop_after,
                         input int chain_k);
        int         n, c;
        bit         have_prev, broken;
        logic [7:0] prev;
        exp_t       e;
        n = 0; c = 0; have_prev = 1'b0; broken = 1'b0; prev = 8'h00;
        while (sb.size() > 0 && c < 2000 && !broken && !(stop_after > 0 && n >= stop_after)) begin
            start = (c == inject_at);
            if (c == inject_at) k = 4'd5;
            n_cmp++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL stream_valid k=%0d xfer=%0d: valid=%b busy=%b, required 1/1",
                         cur_k, n, out_valid, busy);
                broken = 1'b1;
            end else begin
                e = sb[0];
                n_cmp++;
                if (out_word !== e.word || out_last !== e.last || out_index !== e.idx) begin
                    n_err++;
                    $display("FAIL stream_data k=%0d: word=%h last=%b idx=%0d, required %h/%b/%0d",
                             cur_k, out_word, out_last, out_index, e.word, e.last, e.idx);
                end
                n_cmp++;
                if ($countones(out_word) != cur_k || (have_prev && out_word <= prev)) begin
                    n_err++;
                    $display("FAIL stream_order k=%0d: word=%h prev=%h, required popcount %0d ascending",
                             cur_k, out_word, prev, cur_k);
                end
                out_ready = ($urandom_range(99) < ready_pct);
                if (out_ready) begin
                    void'(sb.pop_front());
                    prev = out_word;
                    have_prev = 1'b1;
                    n++;
                end
            end
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (c >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout k=%0d: %0d transfers after %0d cycles", cur_k, n, c);
        end
        if (stop_after > 0 || broken) begin
            sb.delete();
        end else begin
            sb.delete();
            n_cmp++;
            if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL done_pulse k=%0d: done=%b valid=%b busy=%b, required 1/0/0",
                         cur_k, done, out_valid, busy);
            end
            n_cmp++;
            if (n != binom[cur_k]) begin
                n_err++;
                $display("FAIL xfer_count k=%0d: %0d, required %0d", cur_k, n, binom[cur_k]);
            end
            if (chain_k >= 0) start_sweep(chain_k);
            else @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL done_width: done=%b, required 0", done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; k = 4'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, err, out_valid, out_last, done} !== 5'b0 || out_word !== 8'h00 || out_index !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: flags=%b word=%h idx=%h, required all zero",
                     {busy, err, out_valid, out_last, done}, out_word, out_index);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_k2();
        start_sweep(2);
        drain(100, -1, 0, -1);
    endtask

    // K=0 followed back-to-back by K=8, started in the done cycle.
    task automatic test_back_to_back();
        start_sweep(0);
        drain(100, -1, 0, 8);
        drain(100, -1, 0, -1);
    endtask

    task automatic test_err();
        int bad[2] = '{9, 15};
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            k = bad[i][KW-1:0];
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL err_pulse k=%0d: err=%b valid=%b busy=%b, required 1/0/0",
                         bad[i], err, out_valid, busy);
            end
            @(negedge clk);
            n_cmp++;
            if (err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL err_clear k=%0d: err=%b valid=%b busy=%b, required 0/0/0",
                         bad[i], err, out_valid, busy);
            end
        end
    endtask

    task automatic test_random_ready();
        start_sweep(4);
        drain(50, -1, 0, -1);
    endtask

    task automatic test_reset_mid();
        start_sweep(3);
        drain(100, -1, 5, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, err, out_valid, out_last, done} !== 5'b0 || out_word !== 8'h00 || out_index !== 8'h00) begin
            n_err++;
            $display("FAIL reset_abort: flags=%b word=%h idx=%h, required all zero",
                     {busy, err, out_valid, out_last, done}, out_word, out_index);
        end
        start_sweep(1);
        drain(100, -1, 0, -1);
    endtask

    task automatic test_start_while_busy();
        start_sweep(3);
        drain(70, 10, 0, -1);
    endtask

    initial begin
        test_reset();
        test_k2();
        test_back_to_back();
        test_err();
        test_random_ready();
        test_reset_mid();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
